// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame responder: FSM encoding and phase lengths.
package spi_frame_pkg;

    localparam int ADDR_BITS = 16;
    localparam int CTRL_BITS = 8;
    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 5;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS - 1);
    localparam logic [CNT_W-1:0] CTRL_LAST = CNT_W'(CTRL_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_CTRL = 2'd2,
        ST_DATA = 2'd3
    } state_t;

endpackage

// File: rtl/spi_frame_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin plus rise/fall detection
// on the synchronized level.
module spi_frame_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Everything resets low so a pin already low when reset drops creates no edge.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (srst) r_sync[gi] <= 1'b0;
                else      r_sync[gi] <= i_din;
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (srst) r_sync[gi] <= 1'b0;
                else      r_sync[gi] <= r_sync[gi-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) r_prev <= 1'b0;
        else      r_prev <= r_sync[STAGES-1];
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_frame_responder.sv
// SPI mode-0 slave decoding [addr16][ctrl8][data8...] frames into a register bus.
// Optional SPI_FRAME_RESPONDER_ERRCNT_EN adds a saturating err_cnt output.
module spi_frame_responder
    import spi_frame_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int CTRL_RWB_BIT = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        spi_cs,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        frame_active,
    output logic        frame_err
`ifdef SPI_FRAME_RESPONDER_ERRCNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    logic w_srst;
    assign w_srst = rstn;

    // Index 2 = cs, 1 = sck, 0 = mosi.
    logic [2:0] w_din;
    logic [2:0] w_level;
    logic [2:0] w_rise;
    logic [2:0] w_fall;
    assign w_din = {spi_cs, spi_sck, spi_mosi};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        spi_frame_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .srst    (w_srst),
            .i_din   (w_din[gi]),
            .o_level (w_level[gi]),
            .o_rise  (w_rise[gi]),
            .o_fall  (w_fall[gi])
        );
    end

    logic w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall, w_mosi;
    assign w_cs_rise  = w_rise[2];
    assign w_cs_fall  = w_fall[2];
    assign w_sck_rise = w_rise[1];
    assign w_sck_fall = w_fall[1];
    assign w_mosi     = w_level[0];

    logic [3:0] w_unused_sync;
    assign w_unused_sync = {w_level[2], w_level[1], w_rise[0], w_fall[0]};

    state_t           r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [15:0]      r_rx_shift;
    logic [7:0]       r_tx_shift;
    logic             r_rwb;
    logic [15:0]      r_addr;
    logic [7:0]       r_wdata;
    logic             r_we;
    logic             r_re;
    logic             r_re_d;
    logic             r_miso;
    logic             r_active;
    logic             r_err;

    logic [15:0] w_rx_next;
    assign w_rx_next = {r_rx_shift[14:0], w_mosi};

    always_ff @(posedge clk) begin
        if (w_srst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_rwb      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_re_d     <= 1'b0;
            r_miso     <= 1'b0;
            r_active   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_re   <= 1'b0;
            r_err  <= 1'b0;
            r_re_d <= r_re;

            // Write address advances once the strobe cycle has been presented.
            if (r_we) r_addr <= r_addr + 16'd1;

            // Read data arrives one clk after reg_re; only meaningful mid-frame.
            if (r_re_d && r_state == ST_DATA) begin
                r_tx_shift <= reg_rdata;
                r_miso     <= reg_rdata[7];
            end

            if (w_cs_rise) begin
                r_err     <= (r_state == ST_ADDR) || (r_state == ST_CTRL) ||
                             (r_state == ST_DATA && r_bit_cnt != '0);
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
                r_active  <= 1'b0;
                r_miso    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_state    <= ST_ADDR;
                            r_bit_cnt  <= '0;
                            r_rx_shift <= '0;
                            r_tx_shift <= '0;
                            r_miso     <= 1'b0;
                            r_active   <= 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        if (w_sck_rise) begin
                            r_rx_shift <= w_rx_next;
                            if (r_bit_cnt == ADDR_LAST) begin
                                r_addr    <= w_rx_next;
                                r_state   <= ST_CTRL;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_CTRL: begin
                        if (w_sck_rise) begin
                            r_rx_shift <= w_rx_next;
                            if (r_bit_cnt == CTRL_LAST) begin
                                r_rwb     <= w_rx_next[CTRL_RWB_BIT];
                                r_re      <= ~w_rx_next[CTRL_RWB_BIT];
                                r_state   <= ST_DATA;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_sck_rise) begin
                            r_rx_shift <= w_rx_next;
                            if (r_bit_cnt == DATA_LAST) begin
                                r_bit_cnt <= '0;
                                if (r_rwb) begin
                                    r_wdata <= w_rx_next[7:0];
                                    r_we    <= 1'b1;
                                end else begin
                                    r_addr <= r_addr + 16'd1;
                                    r_re   <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else if (w_sck_fall && r_bit_cnt != '0) begin
                            // The falling edge right after a byte boundary keeps the fresh MSB.
                            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                            r_miso     <= r_tx_shift[6];
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign spi_miso     = r_miso;
    assign spi_miso_oe  = r_active;
    assign frame_active = r_active;
    assign reg_addr     = r_addr;
    assign reg_wdata    = r_wdata;
    assign reg_we       = r_we;
    assign reg_re       = r_re;
    assign frame_err    = r_err;

`ifdef SPI_FRAME_RESPONDER_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (w_srst)                          r_err_cnt <= '0;
        else if (r_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_spi_frame_responder.sv
// Bench acting as SPI master and register-bus memory for spi_frame_responder;
// expected strobes and read bytes come from the frame-level rules.
module tb_spi_frame_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        spi_cs, spi_sck, spi_mosi;
    logic        spi_miso, spi_miso_oe;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we, reg_re;
    logic [7:0]  reg_rdata = 8'h00;
    logic        frame_active, frame_err;
`ifdef SPI_FRAME_RESPONDER_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    always #10 clk = ~clk;

    spi_frame_responder dut (
        .clk          (clk),
        .rstn         (rstn),
        .spi_cs       (spi_cs),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_we       (reg_we),
        .reg_re       (reg_re),
        .reg_rdata    (reg_rdata),
        .frame_active (frame_active),
        .frame_err    (frame_err)
`ifdef SPI_FRAME_RESPONDER_ERRCNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [23:0] we_q[$];
    logic [15:0] re_q[$];
    int          err_pulses;
    logic [7:0]  tx_data [0:7];
    logic [7:0]  rx_data [0:7];
    logic [15:0] hdr_miso;
    logic        fa_seen, oe_seen;

    function automatic logic [7:0] mem_read(input logic [15:0] a);
        return a[7:0] + 8'd1;
    endfunction

    // Register-bus memory: read data valid the clk after reg_re.
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= mem_read(reg_addr);
    end

    always @(negedge clk) begin
        if (reg_we)    we_q.push_back({reg_addr, reg_wdata});
        if (reg_re)    re_q.push_back(reg_addr);
        if (frame_err) err_pulses++;
    end

    task automatic clear_mon();
        we_q.delete();
        re_q.delete();
        err_pulses = 0;
    endtask

    task automatic spi_bits(input logic [15:0] val, input int n, output logic [15:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = val[i];
            repeat (HALF) @(negedge clk);
            rx = {rx[14:0], spi_miso};
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [15:0] addr, input logic [7:0] ctrl,
                             input int nbytes, input int partial);
        logic [15:0] rx;
        clear_mon();
        hdr_miso = '0;
        spi_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(addr, 16, rx);
        hdr_miso |= rx;
        spi_bits({8'h00, ctrl}, 8, rx);
        hdr_miso |= rx;
        for (int i = 0; i < nbytes; i++) begin
            spi_bits({8'h00, tx_data[i]}, 8, rx);
            rx_data[i] = rx[7:0];
        end
        if (partial > 0) spi_bits({8'h00, tx_data[nbytes]} >> (8 - partial), partial, rx);
        repeat (HALF) @(negedge clk);
        fa_seen = frame_active;
        oe_seen = spi_miso_oe;
        spi_cs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] exp_zero = 16'h0000;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        checks += 8;
        if (reg_addr !== exp_zero) begin failures++; $display("FAIL reset_addr got=%h exp=%h", reg_addr, exp_zero); end
        if (reg_wdata !== exp_zero[7:0]) begin failures++; $display("FAIL reset_wdata got=%h exp=00", reg_wdata); end
        if (reg_we !== exp_zero[0]) begin failures++; $display("FAIL reset_we got=%b exp=0", reg_we); end
        if (reg_re !== exp_zero[0]) begin failures++; $display("FAIL reset_re got=%b exp=0", reg_re); end
        if (spi_miso !== exp_zero[0]) begin failures++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
        if (spi_miso_oe !== exp_zero[0]) begin failures++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
        if (frame_active !== exp_zero[0]) begin failures++; $display("FAIL reset_active got=%b exp=0", frame_active); end
        if (frame_err !== exp_zero[0]) begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
`ifdef SPI_FRAME_RESPONDER_ERRCNT_EN
        checks++;
        if (err_cnt !== exp_zero[7:0]) begin failures++; $display("FAIL reset_errcnt got=%0d exp=0", err_cnt); end
`endif
        rstn = 1'b0;
        repeat (10) @(negedge clk);
        $display("reset: done");
    endtask

    task automatic test_write();
        tx_data[0] = 8'hA5;
        tx_data[1] = 8'h5A;
        run_frame(16'h0012, 8'h04, 2, 0);
        checks += 5;
        if (we_q.size() != 2) begin failures++; $display("FAIL write_count got=%0d exp=2", we_q.size()); end
        else begin
            if (we_q[0] !== 24'h0012A5) begin failures++; $display("FAIL write_0 got=%h exp=0012a5", we_q[0]); end
            if (we_q[1] !== 24'h00135A) begin failures++; $display("FAIL write_1 got=%h exp=00135a", we_q[1]); end
        end
        if (err_pulses != 0) begin failures++; $display("FAIL write_err got=%0d exp=0", err_pulses); end
        if (fa_seen !== 1'b1 || oe_seen !== 1'b1) begin failures++; $display("FAIL write_active got=%b%b exp=11", fa_seen, oe_seen); end
        $display("write: addr=0012 we=%0d err=%0d", we_q.size(), err_pulses);
    endtask

    task automatic test_read();
        run_frame(16'h0100, 8'h00, 2, 0);
        checks += 6;
        if (rx_data[0] !== 8'h01) begin failures++; $display("FAIL read_miso0 got=%h exp=01", rx_data[0]); end
        if (rx_data[1] !== 8'h02) begin failures++; $display("FAIL read_miso1 got=%h exp=02", rx_data[1]); end
        if (re_q.size() != 3) begin failures++; $display("FAIL read_re_count got=%0d exp=3", re_q.size()); end
        else if (re_q[0] !== 16'h0100 || re_q[1] !== 16'h0101 || re_q[2] !== 16'h0102) begin
            failures++; $display("FAIL read_re_addr got=%h,%h,%h exp=0100,0101,0102", re_q[0], re_q[1], re_q[2]);
        end
        if (we_q.size() != 0) begin failures++; $display("FAIL read_we got=%0d exp=0", we_q.size()); end
        if (hdr_miso !== 16'h0000) begin failures++; $display("FAIL read_hdr_miso got=%h exp=0000", hdr_miso); end
        if (err_pulses != 0) begin failures++; $display("FAIL read_err got=%0d exp=0", err_pulses); end
        $display("read: addr=0100 miso=%h,%h re=%0d", rx_data[0], rx_data[1], re_q.size());
    endtask

    task automatic test_wrap();
        tx_data[0] = 8'h3C;
        tx_data[1] = 8'hC3;
        run_frame(16'hFFFF, 8'h04, 2, 0);
        checks += 3;
        if (we_q.size() != 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", we_q.size()); end
        else if (we_q[0] !== 24'hFFFF3C || we_q[1] !== 24'h0000C3) begin
            failures++; $display("FAIL wrap_addr got=%h,%h exp=ffff3c,0000c3", we_q[0], we_q[1]);
        end
        if (err_pulses != 0) begin failures++; $display("FAIL wrap_err got=%0d exp=0", err_pulses); end
        $display("wrap: we=%0d err=%0d", we_q.size(), err_pulses);
    endtask

    task automatic test_abort();
        logic [15:0] rx;
        clear_mon();
        spi_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(16'h0155, 10, rx);
        repeat (HALF) @(negedge clk);
        spi_cs = 1'b1;
        repeat (12) @(negedge clk);
        checks += 3;
        if (err_pulses != 1) begin failures++; $display("FAIL abort_err got=%0d exp=1", err_pulses); end
        if (we_q.size() != 0) begin failures++; $display("FAIL abort_we got=%0d exp=0", we_q.size()); end
        if (re_q.size() != 0) begin failures++; $display("FAIL abort_re got=%0d exp=0", re_q.size()); end
        $display("abort: err=%0d", err_pulses);
        tx_data[0] = 8'h77;
        run_frame(16'h0234, 8'h04, 1, 0);
        checks += 2;
        if (we_q.size() != 1 || we_q[0] !== 24'h023477) begin
            failures++; $display("FAIL abort_next got_count=%0d exp=023477", we_q.size());
        end
        if (err_pulses != 0) begin failures++; $display("FAIL abort_next_err got=%0d exp=0", err_pulses); end
        $display("abort: next frame we=%0d", we_q.size());
    endtask

    task automatic test_partial();
`ifdef SPI_FRAME_RESPONDER_ERRCNT_EN
        logic [7:0] cnt_before;
        cnt_before = err_cnt;
`endif
        tx_data[0] = 8'h9E;
        tx_data[1] = 8'hFF;
        run_frame(16'h0040, 8'h04, 1, 3);
        checks += 2;
        if (we_q.size() != 1 || we_q[0] !== 24'h00409E) begin
            failures++; $display("FAIL partial_we got_count=%0d exp=1 x 00409e", we_q.size());
        end
        if (err_pulses != 1) begin failures++; $display("FAIL partial_err got=%0d exp=1", err_pulses); end
`ifdef SPI_FRAME_RESPONDER_ERRCNT_EN
        checks++;
        if (err_cnt !== cnt_before + 8'd1) begin
            failures++; $display("FAIL partial_errcnt got=%0d exp=%0d", err_cnt, cnt_before + 8'd1);
        end
`endif
        $display("partial: we=%0d err=%0d", we_q.size(), err_pulses);
    endtask

    task automatic test_reset_mid();
        logic [15:0] rx;
        clear_mon();
        spi_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(16'h0500, 16, rx);
        spi_bits(16'h0004, 8, rx);
        spi_bits(16'h000B, 4, rx);
        rstn = 1'b1;
        @(negedge clk);
        checks += 5;
        if (frame_active !== 1'b0 || spi_miso_oe !== 1'b0) begin failures++; $display("FAIL rstmid_active got=%b%b exp=00", frame_active, spi_miso_oe); end
        if (reg_addr !== 16'h0000) begin failures++; $display("FAIL rstmid_addr got=%h exp=0000", reg_addr); end
        if (reg_we !== 1'b0 || reg_re !== 1'b0) begin failures++; $display("FAIL rstmid_strobe got=%b%b exp=00", reg_we, reg_re); end
        if (reg_wdata !== 8'h00 || spi_miso !== 1'b0 || frame_err !== 1'b0) begin
            failures++; $display("FAIL rstmid_misc got=%h%b%b exp=0000", reg_wdata, spi_miso, frame_err);
        end
        rstn = 1'b0;
        spi_bits(16'h000C, 4, rx);
        repeat (HALF) @(negedge clk);
        spi_cs = 1'b1;
        repeat (12) @(negedge clk);
        if (we_q.size() != 0 || re_q.size() != 0 || err_pulses != 0) begin
            failures++; $display("FAIL rstmid_after got we=%0d re=%0d err=%0d exp=0", we_q.size(), re_q.size(), err_pulses);
        end
        $display("reset_mid: we=%0d re=%0d err=%0d", we_q.size(), re_q.size(), err_pulses);
        tx_data[0] = 8'h42;
        run_frame(16'h0501, 8'h04, 1, 0);
        checks++;
        if (we_q.size() != 1 || we_q[0] !== 24'h050142) begin
            failures++; $display("FAIL rstmid_next got_count=%0d exp=050142", we_q.size());
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 16; f++) begin
            logic [15:0] addr;
            logic [7:0]  ctrl;
            logic        is_wr;
            int          nb, part, bad;
            addr  = 16'($urandom);
            if (f % 4 == 0) addr = 16'hFFFE;
            ctrl  = 8'($urandom);
            is_wr = 1'($urandom);
            ctrl[2] = is_wr;
            nb    = $urandom_range(0, 3);
            part  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int i = 0; i < 8; i++) tx_data[i] = 8'($urandom);
            run_frame(addr, ctrl, nb, part);
            bad = 0;
            checks += 2;
            if (err_pulses != ((part != 0) ? 1 : 0)) begin
                failures++; $display("FAIL rnd%0d_err got=%0d exp=%0d", f, err_pulses, (part != 0) ? 1 : 0);
            end
            if (is_wr) begin
                if (we_q.size() != nb || re_q.size() != 0) bad = 1;
                else for (int i = 0; i < nb; i++)
                    if (we_q[i] !== {addr + 16'(i), tx_data[i]}) bad = 1;
            end else begin
                if (re_q.size() != nb + 1 || we_q.size() != 0 || hdr_miso !== 16'h0000) bad = 1;
                else begin
                    for (int i = 0; i <= nb; i++)
                        if (re_q[i] !== addr + 16'(i)) bad = 1;
                    for (int i = 0; i < nb; i++)
                        if (rx_data[i] !== mem_read(addr + 16'(i))) bad = 1;
                end
            end
            if (bad != 0) begin
                failures++;
                $display("FAIL rnd%0d_data wr=%b addr=%h nb=%0d got we=%0d re=%0d exp_strobes=%0d",
                         f, is_wr, addr, nb, we_q.size(), re_q.size(), is_wr ? nb : nb + 1);
            end
            $display("random %0d: wr=%b addr=%h bytes=%0d partial=%0d we=%0d re=%0d err=%0d",
                     f, is_wr, addr, nb, part, we_q.size(), re_q.size(), err_pulses);
        end
    endtask

    initial begin
        rstn     = 1'b1;
        spi_cs   = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        err_pulses = 0;
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_abort();
        test_partial();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
